// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Shares one 4x4 sequential shift-add multiplier between N_REQ clients.
//   A round-robin search picks a requester. Its operands are latched and the
//   multiplier is started. The arbiter then waits for the multiplier's valid and
//   returns the product tagged with the client id. A watchdog turns a stalled
//   multiplier into an error response.
//
// Ports
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   req_i  [N_REQ]          per-client request, held until its gnt_o bit pulses
//   a_i, b_i [4*N_REQ]      per-client operands, client k at [4k+3:4k]
//   gnt_o  [N_REQ]          one-hot 1-cycle grant pulse
//   rsp_valid_o             1-cycle response pulse
//   rsp_id_o                client id of the response
//   rsp_result_o [8]        product (0 on error)
//   rsp_err_o               response is a timeout error
//   busy_o                  operation in progress (ISSUE/WAIT/RESP)
//   mul_start_o, mul_a_o, mul_b_o             to the multiplier
//   mul_busy_i, mul_valid_i, mul_result_i     from the multiplier
module mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [4*N_REQ-1:0]       a_i,
    input  logic [4*N_REQ-1:0]       b_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic                     rsp_valid_o,
    output logic [$clog2(N_REQ)-1:0] rsp_id_o,
    output logic [7:0]               rsp_result_o,
    output logic                     rsp_err_o,
    output logic                     busy_o,
    output logic                     mul_start_o,
    output logic [3:0]               mul_a_o,
    output logic [3:0]               mul_b_o,
    input  logic                     mul_busy_i,
    input  logic                     mul_valid_i,
    input  logic [7:0]               mul_result_i
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [3:0]        a_q, a_d;
    logic [3:0]        b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        result_q, result_d;
    logic              err_q, err_d;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [3:0]        win_a;
    logic [3:0]        win_b;
    int                idx;

    // Busy from the multiplier is informational only.
    logic unused_mul_busy;
    assign unused_mul_busy = mul_busy_i;

    // Round-robin search: start at rr_q, walk upward with wrap, first set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_id    = idx[ID_W-1:0];
            end
        end
        win_a = a_i[4*win_id +: 4];
        win_b = b_i[4*win_id +: 4];
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (win_found) begin
                    id_d    = win_id;
                    a_d     = win_a;
                    b_d     = win_b;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                rr_d    = (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A valid in the timeout cycle still counts as a good result.
                if (mul_valid_i) begin
                    result_d = mul_result_i;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = 8'd0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Response fields are gated so they read 0 outside the RESP pulse.
    always_comb begin
        gnt_o        = (state_q == S_ISSUE) ? (N_REQ'(1) << id_q) : '0;
        mul_start_o  = (state_q == S_ISSUE);
        rsp_valid_o  = (state_q == S_RESP);
        rsp_id_o     = rsp_valid_o ? id_q : '0;
        rsp_result_o = rsp_valid_o ? result_q : 8'd0;
        rsp_err_o    = rsp_valid_o ? err_q : 1'b0;
        busy_o       = (state_q != S_IDLE);
        mul_a_o      = a_q;
        mul_b_o      = b_q;
    end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 15;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_i;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic [3:0]  gnt_o;
    logic        rsp_valid_o;
    logic [1:0]  rsp_id_o;
    logic [7:0]  rsp_result_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        mul_start_o;
    logic [3:0]  mul_a_o;
    logic [3:0]  mul_b_o;
    logic        mul_busy_i;
    logic        mul_valid_i;
    logic [7:0]  mul_result_i;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    mult_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .a_i(a_i), .b_i(b_i),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
        .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_busy_i(mul_busy_i), .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i)
    );

    // Multiplier model: 4 CALC cycles re-reading the operand lines, then DONE
    // holding valid until the next start. stall masks valid to force a timeout.
    logic [1:0] m_state;
    logic [1:0] m_cnt;
    logic [7:0] m_res;
    logic       stall = 1'b0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_state <= 2'd0;
            m_cnt   <= 2'd0;
            m_res   <= 8'd0;
        end else begin
            case (m_state)
                2'd1: begin
                    m_res <= {4'd0, mul_a_o} * {4'd0, mul_b_o};
                    m_cnt <= m_cnt + 2'd1;
                    if (m_cnt == 2'd3) m_state <= 2'd2;
                end
                default: begin
                    if (mul_start_o) begin
                        m_state <= 2'd1;
                        m_cnt   <= 2'd0;
                    end
                end
            endcase
        end
    end

    assign mul_busy_i   = (m_state == 2'd1);
    assign mul_valid_i  = (m_state == 2'd2) && !stall;
    assign mul_result_i = m_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic set_op(input int k, input logic [3:0] a, input logic [3:0] b);
        a_i[4*k +: 4] = a;
        b_i[4*k +: 4] = b;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] id,
                           input logic [7:0] res, input logic err);
        chk({tag, "_valid"}, 32'(rsp_valid_o), 32'(1));
        chk({tag, "_id"}, 32'(rsp_id_o), 32'(id));
        chk({tag, "_result"}, 32'(rsp_result_o), 32'(res));
        chk({tag, "_err"}, 32'(rsp_err_o), 32'(err));
    endtask

    initial begin
        rst_i = 1'b1;
        req_i = '0;
        a_i   = '0;
        b_i   = '0;
        tick(2);
        chk("rst_gnt", 32'(gnt_o), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_start", 32'(mul_start_o), 32'(0));
        chk("rst_mul_a", 32'(mul_a_o), 32'(0));
        chk("rst_mul_b", 32'(mul_b_o), 32'(0));
        rst_i = 1'b0;
        tick(1);

        // Single request, client 1, 7x9.
        set_op(1, 4'd7, 4'd9);
        req_i = 4'b0010;
        tick(1);
        chk("t1_gnt", 32'(gnt_o), 32'(4'b0010));
        chk("t1_start", 32'(mul_start_o), 32'(1));
        chk("t1_busy", 32'(busy_o), 32'(1));
        chk("t1_mul_a", 32'(mul_a_o), 32'(7));
        chk("t1_mul_b", 32'(mul_b_o), 32'(9));
        req_i = '0;
        tick(1);
        chk("t1_start_off", 32'(mul_start_o), 32'(0));
        tick(4);
        chk("t1_rsp_early", 32'(rsp_valid_o), 32'(0));
        tick(1);
        chk_rsp("t1", 2'd1, 8'd63, 1'b0);
        tick(1);
        chk("t1_idle", 32'(busy_o), 32'(0));

        // Pointer is now 2: client 3 must beat client 0.
        set_op(3, 4'd2, 4'd2);
        set_op(0, 4'd2, 4'd5);
        req_i = 4'b1001;
        tick(1);
        chk("rr_gnt3", 32'(gnt_o), 32'(4'b1000));
        req_i = '0;
        tick(6);
        chk_rsp("rr3", 2'd3, 8'd4, 1'b0);
        tick(1);

        // Fairness: pointer now 0, clients 0 and 3 -> 0 then 3 back to back.
        req_i = 4'b1001;
        tick(1);
        chk("fair_gnt0", 32'(gnt_o), 32'(4'b0001));
        req_i = 4'b1000;
        tick(6);
        chk_rsp("fair0", 2'd0, 8'd10, 1'b0);
        tick(1);
        chk("fair_gnt3", 32'(gnt_o), 32'(4'b1000));
        req_i = '0;
        tick(6);
        chk_rsp("fair3", 2'd3, 8'd4, 1'b0);
        tick(1);

        // All four at once after reset: grants 0,1,2,3 every 7 cycles.
        do_reset();
        set_op(0, 4'd15, 4'd15);
        set_op(1, 4'd3, 4'd4);
        set_op(2, 4'd0, 4'd9);
        set_op(3, 4'd1, 4'd1);
        req_i = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_res;
            case (k)
                0: exp_res = 8'd225;
                1: exp_res = 8'd12;
                2: exp_res = 8'd0;
                default: exp_res = 8'd1;
            endcase
            tick(1);
            chk($sformatf("all_gnt%0d", k), 32'(gnt_o), 32'(4'b0001 << k));
            req_i[k] = 1'b0;
            tick(6);
            chk_rsp($sformatf("all%0d", k), 2'(k), exp_res, 1'b0);
        end
        tick(1);
        // Pointer wrapped to 0: client 1 beats client 3.
        req_i = 4'b1010;
        tick(1);
        chk("wrap_gnt", 32'(gnt_o), 32'(4'b0010));
        req_i = '0;
        tick(6);
        chk_rsp("wrap", 2'd1, 8'd12, 1'b0);
        tick(1);

        // Timeout: multiplier never reports valid.
        stall = 1'b1;
        set_op(0, 4'd3, 4'd3);
        req_i = 4'b0001;
        tick(1);
        chk("to_gnt", 32'(gnt_o), 32'(4'b0001));
        req_i = '0;
        tick(TIMEOUT);
        chk("to_rsp_early", 32'(rsp_valid_o), 32'(0));
        tick(1);
        chk_rsp("to", 2'd0, 8'd0, 1'b1);
        tick(1);
        stall = 1'b0;
        set_op(2, 4'd5, 4'd6);
        req_i = 4'b0100;
        tick(1);
        chk("to_next_gnt", 32'(gnt_o), 32'(4'b0100));
        req_i = '0;
        tick(6);
        chk_rsp("to_next", 2'd2, 8'd30, 1'b0);
        tick(1);

        // Reset during WAIT aborts the operation.
        set_op(1, 4'd2, 4'd3);
        set_op(3, 4'd1, 4'd1);
        req_i = 4'b0010;
        tick(1);
        chk("rw_gnt", 32'(gnt_o), 32'(4'b0010));
        req_i = '0;
        tick(2);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        chk("rw_busy", 32'(busy_o), 32'(0));
        chk("rw_gnt0", 32'(gnt_o), 32'(0));
        chk("rw_start", 32'(mul_start_o), 32'(0));
        chk("rw_rsp_valid", 32'(rsp_valid_o), 32'(0));
        chk("rw_mul_a", 32'(mul_a_o), 32'(0));
        chk("rw_mul_b", 32'(mul_b_o), 32'(0));
        tick(3);
        chk("rw_no_rsp", 32'(rsp_valid_o), 32'(0));
        req_i = 4'b1010;
        tick(1);
        chk("rw_ptr_gnt", 32'(gnt_o), 32'(4'b0010));
        req_i = '0;
        tick(6);
        chk_rsp("rw", 2'd1, 8'd6, 1'b0);
        tick(1);

        // Stale valid: op 2 is issued while the multiplier still shows DONE.
        set_op(0, 4'd4, 4'd5);
        set_op(1, 4'd6, 4'd7);
        req_i = 4'b0011;
        tick(1);
        chk("sv_gnt0", 32'(gnt_o), 32'(4'b0001));
        req_i = 4'b0010;
        tick(6);
        chk_rsp("sv0", 2'd0, 8'd20, 1'b0);
        tick(1);
        chk("sv_gnt1", 32'(gnt_o), 32'(4'b0010));
        req_i = '0;
        tick(1);
        chk("sv_no_early", 32'(rsp_valid_o), 32'(0));
        chk("sv_busy", 32'(busy_o), 32'(1));
        tick(5);
        chk_rsp("sv1", 2'd1, 8'd42, 1'b0);
        tick(1);
        chk("sv_idle", 32'(busy_o), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
